clk_set_ctrl: RTL and testbench

//  Front-panel time-set controller for the digital clock. Debounces the raw mode/up/down

---
 rtl/clk_pkg.sv | 31 +++
 rtl/clk_set_ctrl_debounce.sv | 59 +++++
 rtl/clk_set_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_clk_set_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared encodings for the digital clock front-panel controller: mode states,
// blink field select codes and the helpers that map between them.
package clk_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SET_MI = 2'd1,
      ST_SET_HR = 2'd2
   } state_e;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_MI   = 2'b01;
   localparam logic [1:0] SEL_HR   = 2'b10;

   function automatic state_e next_mode(input state_e st);
      case (st)
         ST_RUN:    return ST_SET_MI;
         ST_SET_MI: return ST_SET_HR;
         default:   return ST_RUN;
      endcase
   endfunction

   function automatic logic [1:0] field_sel(input state_e st);
      case (st)
         ST_SET_MI: return SEL_MI;
         ST_SET_HR: return SEL_HR;
         default:   return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/clk_set_ctrl_debounce.sv
// One front-panel button: 2-flop synchronizer, debounce counter, debounced level
// and a single-cycle press event on each debounced 0->1 transition.
module btn_debounce
   import clk_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          meta_q;
   logic          sync_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The count only runs while the synchronized input disagrees with the
   // debounced level; a single agreeing sample (a bounce) clears it.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            press_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/clk_set_ctrl.sv
// Front-panel time-set controller: RUN/SET_MI/SET_HR mode FSM with auto-repeat
// of up/down, idle timeout back to RUN and a blink request for the edited field.
module clk_set_ctrl
   import clk_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 20,
   parameter int REPEAT_DLY   = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int TIMEOUT_CYC  = 1000,
   parameter int BLINK_HALF   = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       enable_cnt_mi,
   output logic       increase_mi,
   output logic       decrease_mi,
   output logic       enable_cnt_h,
   output logic       increase_h,
   output logic       decrease_h,
   output logic       blink,
   output logic [1:0] blink_sel
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = $clog2(REPEAT_DLY + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);

   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_RATE);
   localparam logic [BW-1:0] BLK_LAST   = BW'(BLINK_HALF - 1);

   logic mode_ev, up_ev, dn_ev;
   logic unused_mode_lvl, up_lvl, dn_lvl;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_mode),
      .level_o (unused_mode_lvl),
      .press_o (mode_ev)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_up),
      .level_o (up_lvl),
      .press_o (up_ev)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_down),
      .level_o (dn_lvl),
      .press_o (dn_ev)
   );

   state_e        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] rpt_q, rpt_d;
   logic          armed_q, armed_d;
   logic          rpt_up_q, rpt_up_d;
   logic [BW-1:0] blk_cnt_q, blk_cnt_d;
   logic          blink_q, blink_d;
   logic          en_mi_q, en_h_q;
   logic          inc_mi_q, dec_mi_q, inc_h_q, dec_h_q;
   logic [1:0]    sel_q;
   logic          any_ev, both_held, chg;
   logic          fire_up, fire_dn;

   // Mode transitions and idle timeout; a mode event always takes priority.
   always_comb begin
      any_ev    = mode_ev | up_ev | dn_ev;
      both_held = up_lvl & dn_lvl;
      state_d   = state_q;
      tmo_d     = '0;
      if (mode_ev) begin
         state_d = next_mode(state_q);
      end else if (state_q != ST_RUN && !any_ev) begin
         if (tmo_q >= TMO_LAST) begin
            state_d = ST_RUN;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      chg = (state_d != state_q);
   end

   // Auto-repeat: a fresh press arms the held direction; any mode change, RUN,
   // release or both buttons down disarms it until the next press event.
   always_comb begin
      fire_up  = 1'b0;
      fire_dn  = 1'b0;
      armed_d  = armed_q;
      rpt_up_d = rpt_up_q;
      rpt_d    = rpt_q;
      if (chg || both_held || state_q == ST_RUN) begin
         armed_d = 1'b0;
         rpt_d   = '0;
      end else if (up_ev) begin
         fire_up  = 1'b1;
         armed_d  = 1'b1;
         rpt_up_d = 1'b1;
         rpt_d    = '0;
      end else if (dn_ev) begin
         fire_dn  = 1'b1;
         armed_d  = 1'b1;
         rpt_up_d = 1'b0;
         rpt_d    = '0;
      end else if (armed_q && (rpt_up_q ? up_lvl : dn_lvl)) begin
         if (rpt_q == RPT_LAST) begin
            fire_up = rpt_up_q;
            fire_dn = !rpt_up_q;
            rpt_d   = RPT_RELOAD;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end else begin
         armed_d = 1'b0;
         rpt_d   = '0;
      end
   end

   always_comb begin
      blk_cnt_d = '0;
      blink_d   = 1'b0;
      if (!chg && state_q != ST_RUN) begin
         if (blk_cnt_q == BLK_LAST) begin
            blink_d = ~blink_q;
         end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            blink_d   = blink_q;
         end
      end
   end

   // Outputs decode from the next state so enables follow the mode event by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         tmo_q     <= '0;
         rpt_q     <= '0;
         armed_q   <= 1'b0;
         rpt_up_q  <= 1'b0;
         blk_cnt_q <= '0;
         blink_q   <= 1'b0;
         en_mi_q   <= 1'b1;
         en_h_q    <= 1'b1;
         inc_mi_q  <= 1'b0;
         dec_mi_q  <= 1'b0;
         inc_h_q   <= 1'b0;
         dec_h_q   <= 1'b0;
         sel_q     <= SEL_NONE;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         rpt_q     <= rpt_d;
         armed_q   <= armed_d;
         rpt_up_q  <= rpt_up_d;
         blk_cnt_q <= blk_cnt_d;
         blink_q   <= blink_d;
         en_mi_q   <= (state_d == ST_RUN);
         en_h_q    <= (state_d != ST_SET_HR);
         inc_mi_q  <= fire_up && (state_q == ST_SET_MI);
         dec_mi_q  <= fire_dn && (state_q == ST_SET_MI);
         inc_h_q   <= fire_up && (state_q == ST_SET_HR);
         dec_h_q   <= fire_dn && (state_q == ST_SET_HR);
         sel_q     <= field_sel(state_d);
      end
   end

   assign enable_cnt_mi = en_mi_q;
   assign enable_cnt_h  = en_h_q;
   assign increase_mi   = inc_mi_q;
   assign decrease_mi   = dec_mi_q;
   assign increase_h    = inc_h_q;
   assign decrease_h    = dec_h_q;
   assign blink         = blink_q;
   assign blink_sel     = sel_q;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Bench for clk_set_ctrl: directed front-panel scenarios plus randomized button
// traffic, all checked every cycle against a behavioural model of the controller.
module tb_clk_set_ctrl;

   localparam int DB = 4;
   localparam int RD = 16;
   localparam int RR = 4;
   localparam int TO = 64;
   localparam int BH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       enable_cnt_mi, increase_mi, decrease_mi;
   logic       enable_cnt_h, increase_h, decrease_h;
   logic       blink;
   logic [1:0] blink_sel;

   always #5 clk = ~clk;

   clk_set_ctrl #(
      .DEBOUNCE_CYC (DB),
      .REPEAT_DLY   (RD),
      .REPEAT_RATE  (RR),
      .TIMEOUT_CYC  (TO),
      .BLINK_HALF   (BH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_mode      (btn_mode),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .enable_cnt_mi (enable_cnt_mi),
      .increase_mi   (increase_mi),
      .decrease_mi   (decrease_mi),
      .enable_cnt_h  (enable_cnt_h),
      .increase_h    (increase_h),
      .decrease_h    (decrease_h),
      .blink         (blink),
      .blink_sel     (blink_sel)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model. Index 0 = mode, 1 = up, 2 = down.
   // m_mode: 0 RUN, 1 minute set, 2 hour set. m_held: button being auto-repeated, -1 none.
   int         m_s1[3], m_s2[3], m_lvl[3], m_run[3], m_ev[3], m_raw[3];
   int         m_mode = 0, m_idle = 0, m_held = -1, m_age = 0, m_phase = 0;
   int         nm, fu, fd, both, evud, m_blk;
   logic [8:0] m_out = 9'b100100000;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_ev[b] = 0;
         end
         m_mode = 0; m_idle = 0; m_held = -1; m_age = 0; m_phase = 0;
         m_out = 9'b100100000;
      end else begin
         m_raw[0] = int'(btn_mode); m_raw[1] = int'(btn_up); m_raw[2] = int'(btn_down);
         evud = (m_ev[1] != 0 || m_ev[2] != 0) ? 1 : 0;
         both = (m_lvl[1] != 0 && m_lvl[2] != 0) ? 1 : 0;
         nm = m_mode;
         if (m_ev[0] != 0) nm = (m_mode + 1) % 3;
         else if (m_mode != 0 && evud == 0 && m_idle + 1 == TO) nm = 0;
         fu = 0; fd = 0;
         if (nm != m_mode || both != 0 || m_mode == 0) m_held = -1;
         else if (m_ev[1] != 0) begin fu = 1; m_held = 1; m_age = 0; end
         else if (m_ev[2] != 0) begin fd = 1; m_held = 2; m_age = 0; end
         else if (m_held > 0 && m_lvl[m_held] != 0) begin
            m_age++;
            if (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0)) begin
               fu = (m_held == 1) ? 1 : 0;
               fd = (m_held == 2) ? 1 : 0;
            end
         end else m_held = -1;
         m_idle  = (nm == 0 || nm != m_mode || evud != 0) ? 0 : m_idle + 1;
         m_phase = (nm == 0 || nm != m_mode) ? 0 : m_phase + 1;
         m_blk   = (nm != 0 && (m_phase / BH) % 2 == 1) ? 1 : 0;
         m_out = {nm == 0, fu != 0 && m_mode == 1, fd != 0 && m_mode == 1,
                  nm != 2, fu != 0 && m_mode == 2, fd != 0 && m_mode == 2,
                  m_blk != 0, 2'(nm)};
         m_mode = nm;
         for (int b = 0; b < 3; b++) begin
            m_run[b] = (m_s2[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
            m_ev[b]  = 0;
            if (m_run[b] == DB) begin
               m_lvl[b] = m_s2[b];
               m_ev[b]  = m_s2[b];
               m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = m_raw[b];
         end
      end
   end

   // Per-cycle comparison plus bookkeeping used by the directed literal checks.
   int         cyc = 0;
   int         n_inc_mi = 0, n_dec_mi = 0, n_inc_h = 0, n_dec_h = 0, n_sel_chg = 0;
   int         inc_mi_t[$];
   int         blink_t[$];
   logic       prev_blink = 1'b0;
   logic [1:0] prev_sel = 2'b00;
   logic [8:0] dut_out;

   always @(negedge clk) begin
      cyc++;
      dut_out = {enable_cnt_mi, increase_mi, decrease_mi, enable_cnt_h,
                 increase_h, decrease_h, blink, blink_sel};
      chk("outputs_vs_model", int'(dut_out), int'(m_out));
      chk("at_most_one_pulse",
          int'($countones({increase_mi, decrease_mi, increase_h, decrease_h}) <= 1), 1);
      chk("pulse_while_enabled",
          int'(((increase_mi | decrease_mi) & enable_cnt_mi) |
               ((increase_h | decrease_h) & enable_cnt_h)), 0);
      if (increase_mi) begin n_inc_mi++; inc_mi_t.push_back(cyc); end
      if (decrease_mi) n_dec_mi++;
      if (increase_h)  n_inc_h++;
      if (decrease_h)  n_dec_h++;
      if (blink != prev_blink) blink_t.push_back(cyc);
      if (blink_sel != prev_sel) n_sel_chg++;
      prev_blink = blink;
      prev_sel   = blink_sel;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; step(8);
      btn_mode = 1'b0; step(8);
   endtask

   function automatic int pulses();
      return n_inc_mi + n_dec_mi + n_inc_h + n_dec_h;
   endfunction

   int b_inc, b_dmi, b_ih, b_dh, b_sel, b_blk, b_pul;
   int exp_off[7] = '{0, 16, 20, 24, 28, 32, 36};
   int cd[3];

   initial begin
      // 1. Reset and idle.
      rst = 1'b0; step(3);
      rst = 1'b1; step(100);
      chk("idle_en_mi", int'(enable_cnt_mi), 1);
      chk("idle_en_h", int'(enable_cnt_h), 1);
      chk("idle_blink", int'(blink), 0);
      chk("idle_sel", int'(blink_sel), 0);
      chk("idle_pulses", pulses(), 0);

      // 2. Bouncy mode press.
      b_sel = n_sel_chg; b_blk = blink_t.size();
      btn_mode = 1'b1; step(2);
      btn_mode = 1'b0; step(2);
      btn_mode = 1'b1; step(30);
      chk("bounce_one_mode_event", n_sel_chg - b_sel, 1);
      chk("set_mi_en_mi", int'(enable_cnt_mi), 0);
      chk("set_mi_en_h", int'(enable_cnt_h), 1);
      chk("set_mi_sel", int'(blink_sel), 1);
      chk("blink_toggles", blink_t.size() - b_blk, 2);
      if (blink_t.size() - b_blk >= 2)
         chk("blink_half_period", blink_t[blink_t.size()-1] - blink_t[blink_t.size()-2], BH);
      btn_mode = 1'b0; step(8);

      // 3. Held up in SET_MI: initial pulse then auto-repeat.
      b_inc = inc_mi_t.size(); b_dmi = n_dec_mi; b_ih = n_inc_h; b_dh = n_dec_h;
      btn_up = 1'b1; step(40);
      btn_up = 1'b0; step(10);
      chk("repeat_count", inc_mi_t.size() - b_inc, 7);
      if (inc_mi_t.size() - b_inc == 7)
         for (int i = 0; i < 7; i++)
            chk("repeat_offset", inc_mi_t[b_inc+i] - inc_mi_t[b_inc], exp_off[i]);
      chk("repeat_no_dec_mi", n_dec_mi - b_dmi, 0);
      chk("repeat_no_inc_h", n_inc_h - b_ih, 0);
      chk("repeat_no_dec_h", n_dec_h - b_dh, 0);
      step(70);
      chk("timeout_en_mi", int'(enable_cnt_mi), 1);
      chk("timeout_sel", int'(blink_sel), 0);

      // 4. Into SET_HR, one down press, then back to RUN.
      press_mode(); press_mode();
      chk("set_hr_en_mi", int'(enable_cnt_mi), 0);
      chk("set_hr_en_h", int'(enable_cnt_h), 0);
      chk("set_hr_sel", int'(blink_sel), 2);
      b_dh = n_dec_h; b_pul = pulses();
      btn_down = 1'b1; step(8);
      btn_down = 1'b0; step(8);
      chk("down_one_dec_h", n_dec_h - b_dh, 1);
      chk("down_only_pulse", pulses() - b_pul, 1);
      chk("down_en_h", int'(enable_cnt_h), 0);
      press_mode();
      chk("back_run_en_mi", int'(enable_cnt_mi), 1);
      chk("back_run_en_h", int'(enable_cnt_h), 1);

      // 5. Up and down together, then idle timeout.
      press_mode(); press_mode();
      b_pul = pulses();
      btn_up = 1'b1; btn_down = 1'b1; step(40);
      btn_up = 1'b0; btn_down = 1'b0; step(80);
      chk("both_held_no_pulse", pulses() - b_pul, 0);
      chk("both_timeout_en_mi", int'(enable_cnt_mi), 1);
      chk("both_timeout_en_h", int'(enable_cnt_h), 1);

      // 6. Reset while editing with up held.
      press_mode();
      btn_up = 1'b1; step(25);
      rst = 1'b0; #1;
      chk("rst_en_mi", int'(enable_cnt_mi), 1);
      chk("rst_en_h", int'(enable_cnt_h), 1);
      chk("rst_sel", int'(blink_sel), 0);
      b_pul = pulses();
      step(5);
      rst = 1'b1; step(20);
      chk("rst_no_pulse", pulses() - b_pul, 0);
      chk("rst_held_up_run", int'(enable_cnt_mi), 1);
      btn_up = 1'b0; step(10);

      // Mode held through reset debounces again and enters SET_MI.
      btn_mode = 1'b1; step(2);
      rst = 1'b0; step(3);
      rst = 1'b1; step(15);
      chk("held_mode_after_rst_sel", int'(blink_sel), 1);
      btn_mode = 1'b0; step(80);

      // Randomized button traffic with occasional bounces and resets.
      for (int b = 0; b < 3; b++) cd[b] = $urandom_range(1, 20);
      for (int i = 0; i < 5000; i++) begin
         for (int b = 0; b < 3; b++) begin
            if (cd[b] == 0) begin
               case (b)
                  0:       btn_mode = ~btn_mode;
                  1:       btn_up   = ~btn_up;
                  default: btn_down = ~btn_down;
               endcase
               if ($urandom_range(0, 3) == 0) cd[b] = $urandom_range(1, 3);
               else cd[b] = $urandom_range(5, (b == 0) ? 150 : 60);
            end else begin
               cd[b]--;
            end
         end
         rst = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
         step(1);
      end

      rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      step(10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
